// File: rtl/lifo_rev_pkg.sv
// rtl/lifo_rev_pkg.sv - shared types and constants for the LIFO packet reverser
//
// Purpose: FSM state encoding and the width of the optional statistics counters.
// Ports:   none (package)
package lifo_rev_pkg;

  typedef enum logic {ST_FILL, ST_DRAIN} rev_state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/lifo_rev_mem.sv
// rtl/lifo_rev_mem.sv - DEPTH x DW register array backing the LIFO stack
//
// Purpose: storage for the stack; synchronous write port, combinational read port.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data
//   raddr  in   read index
//   rdata  out  read data (combinational)
module lifo_rev_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the stack pointer defines validity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_packet_reverser.sv
// rtl/lifo_packet_reverser.sv - stores one packet on a stack and replays it reversed
//
// Purpose: accepts a packet on the s_* valid/ready input, pushes each beat onto a
//   stack, then pops it out on the m_* valid/ready output in reverse order.
//   Beats beyond DEPTH are dropped and flagged on trunc for that packet.
// Optional feature: define LIFO_REV_STATS_EN to add pkt_cnt and drop_cnt outputs.
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   s_valid/s_ready        input handshake (s_ready high only while filling)
//   s_data, s_last         input beat and end-of-packet marker
//   m_valid/m_ready        output handshake (m_valid high only while draining)
//   m_data, m_last         output beat (top of stack), final reversed beat
//   trunc                  current packet lost beats to overflow
//   pkt_cnt, drop_cnt      (LIFO_REV_STATS_EN only) packets drained, beats dropped
module lifo_packet_reverser
  import lifo_rev_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW-1:0]     m_data,
  output logic              m_last,
  output logic              trunc
`ifdef LIFO_REV_STATS_EN
  ,
  output logic [STAT_W-1:0] pkt_cnt,
  output logic [STAT_W-1:0] drop_cnt
`endif
);

  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] SP_FULL = AW'(DEPTH);
  localparam logic [AW-1:0] SP_ONE  = AW'(1);

  rev_state_t    state, state_next;
  logic [AW-1:0] sp;
  logic          full, in_fire, out_fire, store, drop, pop_last;
  logic [IW-1:0] waddr, raddr;

  // Handshakes are derived from state directly rather than from s_ready/m_valid
  // so the FSM output block has no combinational feedback on itself.
  assign full     = (sp == SP_FULL);
  assign in_fire  = s_valid && (state == ST_FILL);
  assign out_fire = m_ready && (state == ST_DRAIN);
  assign store    = in_fire && !full;
  assign drop     = in_fire && full;
  assign pop_last = out_fire && (sp == SP_ONE);

  assign waddr = IW'(sp);
  assign raddr = IW'(sp - SP_ONE);

  lifo_rev_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .clk   (clk),
    .we    (store),
    .waddr (waddr),
    .wdata (s_data),
    .raddr (raddr),
    .rdata (m_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    case (state)
      ST_FILL: begin
        s_ready = 1'b1;
        // A dropped final beat still ends the packet.
        if (s_valid && s_last) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        m_valid = 1'b1;
        m_last  = (sp == SP_ONE);
        if (m_ready && (sp == SP_ONE)) begin
          state_next = ST_FILL;
        end
      end
      default: state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp    <= '0;
      trunc <= 1'b0;
    end else begin
      if (store) begin
        sp <= sp + SP_ONE;
      end else if (out_fire) begin
        sp <= sp - SP_ONE;
      end
      // trunc describes the packet being drained, so it clears with its final pop.
      if (drop) begin
        trunc <= 1'b1;
      end else if (pop_last) begin
        trunc <= 1'b0;
      end
    end
  end

`ifdef LIFO_REV_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (pop_last) begin
        pkt_cnt <= pkt_cnt + STAT_W'(1);
      end
      if (drop && (drop_cnt != {STAT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_lifo_packet_reverser.sv
// tb/tb_lifo_packet_reverser.sv - self-checking bench for lifo_packet_reverser
module tb_lifo_packet_reverser;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic          trunc;
`ifdef LIFO_REV_STATS_EN
  logic [15:0]   pkt_cnt, drop_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int exp_pkt = 0;
  int exp_drop = 0;

  lifo_packet_reverser #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .trunc   (trunc)
`ifdef LIFO_REV_STATS_EN
    ,
    .pkt_cnt (pkt_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one packet, one beat per cycle. Entered and left #1 after a rising edge.
  task automatic send_pkt(input logic [7:0] d[$]);
    for (int i = 0; i < d.size(); i++) begin
      s_valid = 1'b1;
      s_data  = d[i];
      s_last  = (i == d.size() - 1);
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_s_ready beat=%0d got=%b exp=1", i, s_ready);
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Drains the stored packet and compares against the reference: the first
  // min(n,DEPTH) beats sent, in reverse order. stall_idx forces a 5-cycle stall.
  task automatic drain_pkt(input logic [7:0] sent[$], input int stall_prob, input int stall_idx);
    logic [7:0] exp_q[$];
    int   n_keep, idx, budget, stall_left;
    logic exp_tr;
    n_keep = (sent.size() > DEPTH) ? DEPTH : sent.size();
    for (int k = 0; k < n_keep; k++) exp_q.push_front(sent[k]);
    exp_tr = (sent.size() > DEPTH);
    idx = 0; budget = 400; stall_left = 5;
    while (idx < n_keep && budget > 0) begin
      if (idx == stall_idx && stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else begin
        m_ready = ($urandom_range(99, 0) >= stall_prob);
      end
      #1;
      checks++;
      if (m_valid !== 1'b1) begin
        errors++; $display("FAIL drain_m_valid idx=%0d got=%b exp=1", idx, m_valid);
      end
      checks++;
      if (s_ready !== 1'b0) begin
        errors++; $display("FAIL drain_s_ready idx=%0d got=%b exp=0", idx, s_ready);
      end
      checks++;
      if (m_data !== exp_q[idx]) begin
        errors++; $display("FAIL drain_m_data idx=%0d got=%h exp=%h", idx, m_data, exp_q[idx]);
      end
      checks++;
      if (m_last !== (idx == n_keep - 1)) begin
        errors++; $display("FAIL drain_m_last idx=%0d got=%b exp=%b", idx, m_last, (idx == n_keep - 1));
      end
      checks++;
      if (trunc !== exp_tr) begin
        errors++; $display("FAIL drain_trunc idx=%0d got=%b exp=%b", idx, trunc, exp_tr);
      end
      if (m_ready) idx++;
      @(posedge clk); #1;
      budget--;
    end
    m_ready = 1'b0;
    checks++;
    if (idx < n_keep) begin
      errors++; $display("FAIL drain_timeout got=%0d beats exp=%0d", idx, n_keep);
    end
    exp_pkt++;
    exp_drop += sent.size() - n_keep;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL after_drain_handshake got s_ready=%b m_valid=%b exp s_ready=1 m_valid=0", s_ready, m_valid);
    end
    checks++;
    if (trunc !== 1'b0) begin
      errors++; $display("FAIL after_drain_trunc got=%b exp=0", trunc);
    end
`ifdef LIFO_REV_STATS_EN
    checks++;
    if (pkt_cnt !== 16'(exp_pkt)) begin
      errors++; $display("FAIL pkt_cnt got=%0d exp=%0d", pkt_cnt, exp_pkt);
    end
    checks++;
    if (drop_cnt !== 16'(exp_drop)) begin
      errors++; $display("FAIL drop_cnt got=%0d exp=%0d", drop_cnt, exp_drop);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_last !== 1'b0 || trunc !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got s_ready=%b m_valid=%b m_last=%b trunc=%b exp 1 0 0 0", s_ready, m_valid, m_last, trunc);
    end
`ifdef LIFO_REV_STATS_EN
    checks++;
    if (pkt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_counters got pkt=%0d drop=%0d exp 0 0", pkt_cnt, drop_cnt);
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] d[$];
    d = '{8'h11, 8'h22, 8'h33};
    send_pkt(d);
    drain_pkt(d, 0, -1);
  endtask

  task automatic test_overflow();
    logic [7:0] d[$];
    for (int i = 0; i < 20; i++) d.push_back(8'(i));
    send_pkt(d);
    drain_pkt(d, 0, -1);
  endtask

  task automatic test_single();
    logic [7:0] d[$];
    d = '{8'hA5};
    send_pkt(d);
    drain_pkt(d, 0, -1);
  endtask

  task automatic test_full_stall();
    logic [7:0] d[$];
    for (int i = 0; i < DEPTH; i++) d.push_back(8'(8'hC0 + i));
    send_pkt(d);
    drain_pkt(d, 0, 7);
  endtask

  task automatic test_reset_mid_drain();
    logic [7:0] d[$];
    for (int i = 0; i < 10; i++) d.push_back(8'($urandom));
    send_pkt(d);
    m_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
    #1;
    checks++;
    if (m_data !== d[6] || m_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_top got=%h valid=%b exp=%h valid=1", m_data, m_valid, d[6]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_last !== 1'b0 || trunc !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_drain got m_valid=%b s_ready=%b m_last=%b trunc=%b exp 0 1 0 0", m_valid, s_ready, m_last, trunc);
    end
    exp_pkt = 0;
    exp_drop = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    d = '{8'h01, 8'h02};
    send_pkt(d);
    drain_pkt(d, 0, -1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d[$];
    for (int p = 0; p < 3; p++) begin
      d.delete();
      for (int i = 0; i < 3 + p * 4; i++) d.push_back(8'($urandom));
      send_pkt(d);
      // Keep offering beats while draining; none of them may be taken.
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      s_last  = 1'($urandom);
      drain_pkt(d, 0, -1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] d[$];
    for (int p = 0; p < 10; p++) begin
      d.delete();
      for (int i = 0; i < $urandom_range(24, 1); i++) d.push_back(8'($urandom));
      send_pkt(d);
      drain_pkt(d, 35, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_single();
    test_full_stall();
    test_reset_mid_drain();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
